// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmitter family:
// serial format, transmitter FSM states and the 44.1 kHz divider ratio.
package i2s_pkg;

  typedef enum logic {
    I2S_STD = 1'b0,
    I2S_LJ  = 1'b1
  } i2s_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } i2s_state_e;

  // 50 MHz / (2 * 71/4) gives the 35/36-clock BitClk alternation.
  localparam int DIV_NUM_44K1 = 71;
  localparam int DIV_DEN_44K1 = 4;

endpackage

// File: rtl/frac_clk_div.sv
// Fractional tick generator: one tick per DIV_NUM/DIV_DEN clocks on average.
// Holds the accumulator at zero while disabled so every run starts in phase.
module frac_clk_div #(
  parameter int DIV_NUM = 71,
  parameter int DIV_DEN = 4,
  parameter int ACC_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [ACC_W:0] NUM_W = (ACC_W+1)'(DIV_NUM);
  localparam logic [ACC_W:0] DEN_W = (ACC_W+1)'(DIV_DEN);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + DEN_W;
    tick_o = en_i && (sum >= NUM_W);
    if (!en_i) begin
      acc_d = '0;
    end else if (tick_o) begin
      acc_d = ACC_W'(sum - NUM_W);
    end else begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/i2s_tx_param.sv
// Parametrised stereo I2S / left-justified serialiser with a one-deep sample holding register.
// Optional underrun counter port enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_param
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int DIV_NUM  = DIV_NUM_44K1,
  parameter int DIV_DEN  = DIV_DEN_44K1,
  parameter int ACC_W    = 8
) (
  input  logic                CLK50MHZ,
  input  logic                rst,
  input  logic                tx_en,
  input  logic                mode,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                s_ready,
  output logic                BitClk,
  output logic                LrClk,
  output logic                i2sData,
  output logic                frame_start,
  output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  , output logic [15:0]       underrun_cnt
`endif
);

  localparam int SR_W  = 2 * SLOT_W;
  localparam int CNT_W = $clog2(SR_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SR_W - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(SLOT_W);

  i2s_state_e state_q, state_d;
  i2s_mode_e  mode_q, mode_d;
  logic bitclk_q, bitclk_d;
  logic lr_q, lr_d;
  logic data_q, data_d;
  logic fs_q, ur_q;
  logic tail_q, tail_d;
  logic fall_q, fall_d;
  logic full_q, full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SLOT_W-1:0] l_slot, r_slot;
  logic tick, div_en, launch, stop, push, prev_bit;

  assign div_en = (state_q == ACTIVE);

  frac_clk_div #(
    .DIV_NUM (DIV_NUM),
    .DIV_DEN (DIV_DEN),
    .ACC_W   (ACC_W)
  ) u_div (
    .clk_i  (CLK50MHZ),
    .rst_i  (rst),
    .en_i   (div_en),
    .tick_o (tick)
  );

  // Samples sit at the MSB end of their slot; unused low bits are zero.
  assign l_slot = SLOT_W'(hold_l_q) << (SLOT_W - SAMPLE_W);
  assign r_slot = SLOT_W'(hold_r_q) << (SLOT_W - SAMPLE_W);
  assign push   = s_valid && !full_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    bitclk_d = bitclk_q ^ tick;
    lr_d     = lr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    tail_d   = tail_q;
    launch   = 1'b0;
    stop     = 1'b0;
    cnt_nxt  = cnt_q + CNT_W'(1);
    prev_bit = (state_q == ACTIVE) ? sr_q[SR_W-1] : 1'b0;
    fall_d   = div_en && tick && bitclk_q;

    case (state_q)
      IDLE: begin
        bitclk_d = 1'b0;
        lr_d     = 1'b1;
        data_d   = 1'b0;
        if (tx_en) begin
          launch  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (fall_q) begin
          if (tail_q) begin
            stop = 1'b1;
          end else if (cnt_q == LAST) begin
            if (tx_en) begin
              launch = 1'b1;
            end else if (mode_q == I2S_STD) begin
              // I2S lags one bit, so the right LSB still needs its own bit period.
              tail_d = 1'b1;
              data_d = sr_q[SR_W-1];
            end else begin
              stop = 1'b1;
            end
          end else begin
            cnt_d  = cnt_nxt;
            sr_d   = sr_q << 1;
            lr_d   = (cnt_nxt >= HALF);
            data_d = (mode_q == I2S_LJ) ? sr_q[SR_W-2] : sr_q[SR_W-1];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d  = IDLE;
      bitclk_d = 1'b0;
      lr_d     = 1'b1;
      data_d   = 1'b0;
      tail_d   = 1'b0;
    end

    if (launch) begin
      mode_d = i2s_mode_e'(mode);
      cnt_d  = '0;
      lr_d   = 1'b0;
      tail_d = 1'b0;
      sr_d   = full_q ? {l_slot, r_slot} : '0;
      data_d = (mode_d == I2S_LJ) ? sr_d[SR_W-1] : prev_bit;
    end
  end

  // A launch consumes the held pair before a same-cycle push can refill it.
  always_comb begin
    full_d   = full_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (launch && full_q) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d   = 1'b1;
      hold_l_d = s_left;
      hold_r_d = s_right;
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= I2S_STD;
      bitclk_q <= 1'b0;
      lr_q     <= 1'b1;
      data_q   <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
      tail_q   <= 1'b0;
      fall_q   <= 1'b0;
      full_q   <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      bitclk_q <= bitclk_d;
      lr_q     <= lr_d;
      data_q   <= data_d;
      fs_q     <= launch;
      ur_q     <= launch && !full_q;
      tail_q   <= tail_d;
      fall_q   <= fall_d;
      full_q   <= full_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (launch && !full_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign s_ready     = !full_q;
  assign BitClk      = bitclk_q;
  assign LrClk       = lr_q;
  assign i2sData     = data_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_tx_param.sv
// Directed bench for i2s_tx_param: a 16/16 left-justified instance and a 24/32 I2S instance,
// each with a bit-level scoreboard checked at every BitClk rise.
module tb_i2s_tx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic        tx_en_a, mode_a, s_valid_a, s_ready_a, bclk_a, lr_a, dat_a, fs_a, ur_a;
  logic [15:0] l_a, r_a;
  logic        tx_en_b, mode_b, s_valid_b, s_ready_b, bclk_b, lr_b, dat_b, fs_b, ur_b;
  logic [23:0] l_b, r_b;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(16)) dut_a (
    .CLK50MHZ(clk), .rst(rst), .tx_en(tx_en_a), .mode(mode_a), .s_valid(s_valid_a),
    .s_left(l_a), .s_right(r_a), .s_ready(s_ready_a), .BitClk(bclk_a), .LrClk(lr_a),
    .i2sData(dat_a), .frame_start(fs_a), .underrun(ur_a)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt_a)
`endif
  );

  i2s_tx_param #(.SAMPLE_W(24), .SLOT_W(32)) dut_b (
    .CLK50MHZ(clk), .rst(rst), .tx_en(tx_en_b), .mode(mode_b), .s_valid(s_valid_b),
    .s_left(l_b), .s_right(r_b), .s_ready(s_ready_b), .BitClk(bclk_b), .LrClk(lr_b),
    .i2sData(dat_b), .frame_start(fs_b), .underrun(ur_b)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt_b)
`endif
  );

  typedef struct packed {logic lr; logic d;} bit_t;
  bit_t exp_a[$], exp_b[$];
  int   rise_cyc_a[$], fs_rise_b[$];
  int   vectors = 0, miscompares = 0, cyc = 0;
  int   rises_a = 0, falls_a = 0, fs_cnt_a = 0, ur_cnt_a = 0;
  int   rises_b = 0, falls_b = 0, fs_cnt_b = 0, ur_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial stream of one frame; bits holds both slots right-aligned.
  task automatic push_frame(input int which, input logic [63:0] bits, input int slot,
                            input logic lj, input logic prev);
    bit_t e;
    for (int c = 0; c < 2 * slot; c++) begin
      e.lr = (c >= slot);
      e.d  = lj ? bits[2*slot-1-c] : ((c == 0) ? prev : bits[2*slot-c]);
      if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
    end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      0: return rises_a;
      1: return falls_a;
      2: return rises_b;
      default: return falls_b;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int n, input string tag);
    int t = 0;
    while (get_cnt(sel) < n && t < 20000) begin
      @(negedge clk); #1;
      t++;
    end
    check(tag, 32'(get_cnt(sel) >= n), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic pa = 1'b0, pb = 1'b0;
    bit_t e;
    forever begin
      @(negedge clk);
      if (bclk_a && !pa) begin
        rises_a++;
        if (rise_cyc_a.size() < 5) rise_cyc_a.push_back(cyc);
        if (exp_a.size() > 0) begin
          e = exp_a.pop_front();
          check("A_lrclk", 32'(lr_a), 32'(e.lr));
          check("A_data", 32'(dat_a), 32'(e.d));
        end
      end
      if (!bclk_a && pa) falls_a++;
      if (fs_a) fs_cnt_a++;
      if (ur_a) ur_cnt_a++;
      pa = bclk_a;
      if (bclk_b && !pb) begin
        rises_b++;
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          check("B_lrclk", 32'(lr_b), 32'(e.lr));
          check("B_data", 32'(dat_b), 32'(e.d));
        end
      end
      if (!bclk_b && pb) falls_b++;
      if (fs_b) begin
        fs_cnt_b++;
        fs_rise_b.push_back(rises_b);
      end
      if (ur_b) ur_cnt_b++;
      pb = bclk_b;
    end
  end

  initial begin
    logic [63:0] fb1, fb2;
    int total, per;
    tx_en_a = 0; mode_a = 0; s_valid_a = 0; l_a = '0; r_a = '0;
    tx_en_b = 0; mode_b = 0; s_valid_b = 0; l_b = '0; r_b = '0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("rst_bitclk_a", 32'(bclk_a), 32'd0);
    check("rst_lrclk_a", 32'(lr_a), 32'd1);
    check("rst_data_a", 32'(dat_a), 32'd0);
    check("rst_ready_a", 32'(s_ready_a), 32'd1);
    check("rst_pulses_a", 32'({fs_a, ur_a}), 32'd0);
    check("rst_lrclk_b", 32'(lr_b), 32'd1);
    check("rst_ready_b", 32'(s_ready_b), 32'd1);
    rst = 1'b0;

    // Left-justified 16/16: frame 1 data, frame 2 underrun, frame 3 pushed at frame 2 launch.
    l_a = 16'hA5F0; r_a = 16'h0F3C; s_valid_a = 1;
    push_frame(0, {32'd0, 16'hA5F0, 16'h0F3C}, 16, 1'b1, 1'b0);
    push_frame(0, 64'd0, 16, 1'b1, 1'b0);
    @(negedge clk); #1;
    s_valid_a = 0;
    check("A_ready_after_push", 32'(s_ready_a), 32'd0);
    mode_a = 1; tx_en_a = 1;
    @(negedge clk); #1;
    check("A_launch_fs", 32'(fs_a), 32'd1);
    check("A_launch_no_ur", 32'(ur_a), 32'd0);
    check("A_ready_after_launch", 32'(s_ready_a), 32'd1);

    wait_for(0, 5, "A_wait_rise5");
    total = rise_cyc_a[4] - rise_cyc_a[0];
    check("div_total_4_periods", 32'(total), 32'd142);
    for (int i = 0; i < 4; i++) begin
      per = rise_cyc_a[i+1] - rise_cyc_a[i];
      check("div_period_35_36", 32'((per == 35) || (per == 36)), 32'd1);
    end

    wait_for(1, 32, "A_wait_frame1_end");
    l_a = 16'h8001; r_a = 16'h7FFE; s_valid_a = 1;
    push_frame(0, {32'd0, 16'h8001, 16'h7FFE}, 16, 1'b1, 1'b0);
    @(negedge clk); #1;
    s_valid_a = 0;
    check("A_underrun_pulse", 32'(ur_a), 32'd1);
    check("A_held_after_sim_push", 32'(s_ready_a), 32'd0);

    wait_for(0, 70, "A_wait_frame3");
    tx_en_a = 0;
    wait_for(1, 96, "A_wait_frame3_end");
    repeat (80) @(negedge clk);
    #1;
    check("A_idle_bitclk", 32'(bclk_a), 32'd0);
    check("A_idle_lrclk", 32'(lr_a), 32'd1);
    check("A_idle_data", 32'(dat_a), 32'd0);
    check("A_rises_total", 32'(rises_a), 32'd96);
    check("A_frame_starts", 32'(fs_cnt_a), 32'd3);
    check("A_underruns", 32'(ur_cnt_a), 32'd1);
    check("A_queue_empty", 32'(exp_a.size()), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("A_underrun_cnt", 32'(ucnt_a), 32'd1);
`endif

    // I2S 24-in-32: two frames, then one trailing bit before IDLE.
    fb1 = {24'h800001, 8'h00, 24'h7FFFFE, 8'h00};
    l_b = 24'h800001; r_b = 24'h7FFFFE; s_valid_b = 1;
    push_frame(1, fb1, 32, 1'b0, 1'b0);
    @(negedge clk); #1;
    s_valid_b = 0;
    mode_b = 0; tx_en_b = 1;
    wait_for(2, 3, "B_wait_started");
    check("B_ready_in_frame1", 32'(s_ready_b), 32'd1);
    fb2 = {24'h123456, 8'h00, 24'hFEDCBA, 8'h00};
    l_b = 24'h123456; r_b = 24'hFEDCBA; s_valid_b = 1;
    push_frame(1, fb2, 32, 1'b0, fb1[0]);
    e_tail_push(fb2[0]);
    @(negedge clk); #1;
    s_valid_b = 0;
    wait_for(2, 100, "B_wait_frame2");
    tx_en_b = 0;
    wait_for(3, 129, "B_wait_tail_end");
    repeat (80) @(negedge clk);
    #1;
    check("B_idle_bitclk", 32'(bclk_b), 32'd0);
    check("B_idle_lrclk", 32'(lr_b), 32'd1);
    check("B_idle_data", 32'(dat_b), 32'd0);
    check("B_rises_total", 32'(rises_b), 32'd129);
    check("B_frame_starts", 32'(fs_cnt_b), 32'd2);
    check("B_underruns", 32'(ur_cnt_b), 32'd0);
    check("B_queue_empty", 32'(exp_b.size()), 32'd0);
    if (fs_rise_b.size() >= 2)
      check("B_fs_spacing", 32'(fs_rise_b[1] - fs_rise_b[0]), 32'd64);
    else
      check("B_fs_recorded", 32'(fs_rise_b.size()), 32'd2);

    // Abort: reset during bit 10 of a fresh frame.
    tx_en_a = 1;
    wait_for(0, 107, "A_wait_bit10");
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_bitclk", 32'(bclk_a), 32'd0);
    check("abort_lrclk", 32'(lr_a), 32'd1);
    check("abort_data", 32'(dat_a), 32'd0);
    check("abort_ready", 32'(s_ready_a), 32'd1);
    check("abort_pulses", 32'({fs_a, ur_a}), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("abort_underrun_cnt", 32'(ucnt_a), 32'd0);
`endif
    tx_en_a = 0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic e_tail_push(input logic d);
    bit_t e;
    e.lr = 1'b1;
    e.d  = d;
    exp_b.push_back(e);
  endtask

endmodule
